// File: rtl/sprite_pkg.sv
// Shared screen/sprite constants, scheduler state encoding and reset-position helpers
// for the sprite motion scheduler.
package sprite_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SPRITE_W_DEF = 16;
    localparam int SPRITE_H_DEF = 16;
    localparam int POS_W        = 10;
    localparam int STEP_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        COMMIT = 2'd2
    } sched_state_e;

    function automatic logic [POS_W-1:0] init_x(input int i);
        return POS_W'(32 + 64 * i);
    endfunction

    function automatic logic [POS_W-1:0] init_y(input int i);
        return POS_W'(16 + 48 * i);
    endfunction

    // Even sprites start moving right, odd sprites start moving left.
    function automatic logic init_dir_x(input int i);
        return ((i % 2) == 0);
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis bounce step: advances a position by step in the current direction and
// reflects off 0 or limit. Purely combinational; shared across sprites by the top.
module sprite_axis_step
    import sprite_pkg::*;
(
    input  logic [POS_W-1:0]  p_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [POS_W-1:0]  limit_i,
    output logic [POS_W-1:0]  p_next_o,
    output logic              dir_next_o
);

    logic [POS_W:0] n;

    always_comb begin
        p_next_o   = p_i;
        dir_next_o = dir_i;
        n          = '0;
        if (dir_i) begin
            n = {1'b0, p_i} + (POS_W+1)'(step_i);
            if (n > {1'b0, limit_i}) begin
                p_next_o   = limit_i;
                dir_next_o = 1'b0;
            end else begin
                p_next_o = n[POS_W-1:0];
            end
        end else begin
            // Borrow out of the 11-bit difference means the result went below zero.
            n = {1'b0, p_i} - (POS_W+1)'(step_i);
            if (n[POS_W]) begin
                p_next_o   = '0;
                dir_next_o = 1'b1;
            end else begin
                p_next_o = n[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion_scheduler.sv
// Per-frame sprite sequencer: steps sprites one per cycle at vblank start, then commits all
// positions atomically. Define SPRITE_COLLIDE_EN to register sprite-0 overlap flags at commit.
module sprite_motion_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int X_MAX       = SCREEN_W,
    parameter int Y_MAX       = SCREEN_H,
    parameter int SPRITE_W    = SPRITE_W_DEF,
    parameter int SPRITE_H    = SPRITE_H_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   y,
    input  logic                         pause,
    input  logic [1:0]                   speed,
    output logic [10*NUM_SPRITES-1:0]    spr_x,
    output logic [10*NUM_SPRITES-1:0]    spr_y,
    output logic [NUM_SPRITES-1:0]       collide,
    output logic                         busy,
    output logic [7:0]                   frame_count
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX - SPRITE_W);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX - SPRITE_H);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [9:0]             y_prev_q;
    logic [7:0]             frame_count_q, frame_count_d;
    logic [1:0]             speed_q, speed_d;
    logic [POS_W-1:0]       wx_q [NUM_SPRITES];
    logic [POS_W-1:0]       wy_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dx_q, dy_q;
    logic [POS_W-1:0]       cx_q [NUM_SPRITES];
    logic [POS_W-1:0]       cy_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] collide_q, collide_d;

    logic                   vblank_start;
    logic                   step_en, commit_en;
    logic [STEP_W-1:0]      step_amt;
    logic [POS_W-1:0]       x_next, y_next;
    logic                   dx_next, dy_next;

    assign vblank_start = (y == 10'(Y_MAX)) && (y_prev_q != 10'(Y_MAX));
    assign step_amt     = {1'b0, speed_q} + STEP_W'(1);

    // Single adder pair, muxed onto the sprite selected by idx.
    sprite_axis_step u_step_x (
        .p_i        (wx_q[idx_q]),
        .dir_i      (dx_q[idx_q]),
        .step_i     (step_amt),
        .limit_i    (X_LIM),
        .p_next_o   (x_next),
        .dir_next_o (dx_next)
    );

    sprite_axis_step u_step_y (
        .p_i        (wy_q[idx_q]),
        .dir_i      (dy_q[idx_q]),
        .step_i     (step_amt),
        .limit_i    (Y_LIM),
        .p_next_o   (y_next),
        .dir_next_o (dy_next)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_count_d = frame_count_q;
        speed_d       = speed_q;
        step_en       = 1'b0;
        commit_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (vblank_start) begin
                    frame_count_d = frame_count_q + 8'd1;
                    speed_d       = speed;
                    if (!pause) begin
                        idx_d   = '0;
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                step_en = 1'b1;
                if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPRITE_COLLIDE_EN
    // |dx| < W rewritten as two unsigned compares so no signed subtract is needed.
    always_comb begin
        collide_d = '0;
        for (int i = 1; i < NUM_SPRITES; i++) begin
            collide_d[i] = ({1'b0, wx_q[0]} < {1'b0, wx_q[i]} + (POS_W+1)'(SPRITE_W)) &&
                           ({1'b0, wx_q[i]} < {1'b0, wx_q[0]} + (POS_W+1)'(SPRITE_W)) &&
                           ({1'b0, wy_q[0]} < {1'b0, wy_q[i]} + (POS_W+1)'(SPRITE_H)) &&
                           ({1'b0, wy_q[i]} < {1'b0, wy_q[0]} + (POS_W+1)'(SPRITE_H));
        end
    end
`else
    assign collide_d = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            y_prev_q      <= '0;
            frame_count_q <= '0;
            speed_q       <= '0;
            collide_q     <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                wx_q[i] <= init_x(i);
                wy_q[i] <= init_y(i);
                cx_q[i] <= init_x(i);
                cy_q[i] <= init_y(i);
                dx_q[i] <= init_dir_x(i);
                dy_q[i] <= 1'b1;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            y_prev_q      <= y;
            frame_count_q <= frame_count_d;
            speed_q       <= speed_d;
            if (step_en) begin
                wx_q[idx_q] <= x_next;
                wy_q[idx_q] <= y_next;
                dx_q[idx_q] <= dx_next;
                dy_q[idx_q] <= dy_next;
            end
            if (commit_en) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    cx_q[i] <= wx_q[i];
                    cy_q[i] <= wy_q[i];
                end
                collide_q <= collide_d;
            end
        end
    end

    always_comb begin
        spr_x = '0;
        spr_y = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            spr_x[POS_W*i +: POS_W] = cx_q[i];
            spr_y[POS_W*i +: POS_W] = cy_q[i];
        end
    end

    assign collide     = collide_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Self-checking bench for sprite_motion_scheduler: constant vector table for the first
// frames, then a model-fed scoreboard for timing, pause, glitch, reset and bounce sequences.
module tb_sprite_motion_scheduler;

    localparam int NS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        y = '0;
    logic              pause = 1'b0;
    logic [1:0]        speed = '0;
    logic [10*NS-1:0]  spr_x, spr_y;
    logic [NS-1:0]     collide;
    logic              busy;
    logic [7:0]        frame_count;

    always #5 clk = ~clk;

    sprite_motion_scheduler #(.NUM_SPRITES(NS)) dut (
        .clk         (clk),
        .rst         (rst),
        .y           (y),
        .pause       (pause),
        .speed       (speed),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .collide     (collide),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;

    int mx [NS];
    int my [NS];
    bit mdx [NS];
    bit mdy [NS];
    int mfc;

    typedef struct {
        logic [10*NS-1:0] x;
        logic [10*NS-1:0] y;
        logic [NS-1:0]    col;
        logic [7:0]       fc;
    } exp_t;
    exp_t sbq [$];

    typedef struct {
        bit         p;
        logic [1:0] spd;
        int         x0, y0, x1, y1, fc;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic axis(input int p, input bit d, input int s, input int lim,
                        output int pn, output bit dn);
        pn = p;
        dn = d;
        if (d) begin
            if (p + s > lim) begin pn = lim; dn = 1'b0; end
            else pn = p + s;
        end else begin
            if (p - s < 0) begin pn = 0; dn = 1'b1; end
            else pn = p - s;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i]  = 32 + 64 * i;
            my[i]  = 16 + 48 * i;
            mdx[i] = ((i % 2) == 0);
            mdy[i] = 1'b1;
        end
        mfc = 0;
    endtask

    task automatic model_frame(input bit p, input int spd);
        int pn;
        bit dn;
        mfc = (mfc + 1) % 256;
        if (!p) begin
            for (int i = 0; i < NS; i++) begin
                axis(mx[i], mdx[i], spd + 1, 624, pn, dn);
                mx[i] = pn; mdx[i] = dn;
                axis(my[i], mdy[i], spd + 1, 464, pn, dn);
                my[i] = pn; mdy[i] = dn;
            end
        end
    endtask

    function automatic logic [10*NS-1:0] pack_x();
        logic [10*NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) r[10*i +: 10] = 10'(mx[i]);
        return r;
    endfunction

    function automatic logic [10*NS-1:0] pack_y();
        logic [10*NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) r[10*i +: 10] = 10'(my[i]);
        return r;
    endfunction

    function automatic logic [NS-1:0] model_col();
        logic [NS-1:0] r;
        r = '0;
`ifdef SPRITE_COLLIDE_EN
        for (int i = 1; i < NS; i++) begin
            int ddx, ddy;
            ddx = (mx[0] > mx[i]) ? mx[0] - mx[i] : mx[i] - mx[0];
            ddy = (my[0] > my[i]) ? my[0] - my[i] : my[i] - my[0];
            r[i] = (ddx < 16) && (ddy < 16);
        end
`endif
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; y = '0; pause = 1'b0; speed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sbq.delete();
    endtask

    // Drives one vblank start, flips pause/speed mid-sequence (must be ignored),
    // optionally glitches y back through 480 while busy, and checks cycle-exact timing.
    task automatic do_frame(input bit p, input logic [1:0] spd, input bit glitch);
        logic [10*NS-1:0] old_x, old_y;
        exp_t e;
        bit ok;
        @(negedge clk);
        y = 10'd479; pause = p; speed = spd;
        @(negedge clk);
        y = 10'd480;
        old_x = pack_x();
        old_y = pack_y();
        model_frame(p, int'(spd));
        e.x = pack_x(); e.y = pack_y(); e.col = model_col(); e.fc = 8'(mfc);
        sbq.push_back(e);
        ok = 1'b1;
        for (int k = 0; k <= NS + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= NS) begin
                if (busy !== !p || spr_x !== old_x || spr_y !== old_y) ok = 1'b0;
            end else if (busy !== 1'b0) begin
                ok = 1'b0;
            end
            if (k == 0) begin speed = ~spd; pause = ~p; end
            if (glitch && k == 1) y = 10'd479;
            if (glitch && k == 2) y = 10'd480;
        end
        check("seq_timing", 64'(ok), 64'd1);
        e = sbq.pop_front();
        check("sb_spr_x", 64'(spr_x), 64'(e.x));
        check("sb_spr_y", 64'(spr_y), 64'(e.y));
        check("sb_frame_count", 64'(frame_count), 64'(e.fc));
        check("sb_collide", 64'(collide), 64'(e.col));
    endtask

    initial begin
        tbl[0] = '{p: 1'b0, spd: 2'd0, x0: 33, y0: 17, x1: 95, y1: 65, fc: 1};
        tbl[1] = '{p: 1'b0, spd: 2'd1, x0: 35, y0: 19, x1: 93, y1: 67, fc: 2};
        tbl[2] = '{p: 1'b1, spd: 2'd3, x0: 35, y0: 19, x1: 93, y1: 67, fc: 3};
        tbl[3] = '{p: 1'b0, spd: 2'd3, x0: 39, y0: 23, x1: 89, y1: 71, fc: 4};
        tbl[4] = '{p: 1'b0, spd: 2'd2, x0: 42, y0: 26, x1: 86, y1: 74, fc: 5};

        apply_reset();
        check("rst_x0", 64'(spr_x[9:0]), 64'd32);
        check("rst_y0", 64'(spr_y[9:0]), 64'd16);
        check("rst_x1", 64'(spr_x[19:10]), 64'd96);
        check("rst_all_x", 64'(spr_x), 64'(pack_x()));
        check("rst_all_y", 64'(spr_y), 64'(pack_y()));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_collide", 64'(collide), 64'd0);

        for (int v = 0; v < 5; v++) begin
            do_frame(tbl[v].p, tbl[v].spd, 1'b0);
            check("vec_x0", 64'(spr_x[9:0]), 64'(tbl[v].x0));
            check("vec_y0", 64'(spr_y[9:0]), 64'(tbl[v].y0));
            check("vec_x1", 64'(spr_x[19:10]), 64'(tbl[v].x1));
            check("vec_y1", 64'(spr_y[19:10]), 64'(tbl[v].y1));
            check("vec_fc", 64'(frame_count), 64'(tbl[v].fc));
        end

        // y re-enters 480 while busy: only one frame counted and stepped.
        do_frame(1'b0, 2'd1, 1'b1);
        repeat (5) @(negedge clk);
        check("hold_480_fc", 64'(frame_count), 64'd6);
        check("hold_480_busy", 64'(busy), 64'd0);

        for (int f = 0; f < 3; f++) do_frame(1'b1, 2'd2, 1'b0);
        check("pause_fc", 64'(frame_count), 64'd9);
        check("pause_x", 64'(spr_x), 64'(pack_x()));

        // Reset in the middle of a sequence: nothing committed, everything back to init.
        @(negedge clk); y = 10'd479; speed = 2'd3; pause = 1'b0;
        @(negedge clk); y = 10'd480;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1; y = '0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
        check("midrst_x", 64'(spr_x), 64'(pack_x()));
        check("midrst_y", 64'(spr_y), 64'(pack_y()));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_fc", 64'(frame_count), 64'd0);
        @(negedge clk);
        check("midrst_idle", 64'(busy), 64'd0);

        for (int f = 1; f <= 150; f++) begin
            do_frame(1'b0, 2'd3, 1'b0);
            if (f == 148) check("bounce_148", 64'(spr_x[9:0]), 64'd624);
            if (f == 149) check("bounce_149", 64'(spr_x[9:0]), 64'd624);
            if (f == 150) check("bounce_150", 64'(spr_x[9:0]), 64'd620);
        end
        check("wrap_fc", 64'(frame_count), 64'd150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
